// File: rtl/uart_rx_core_if.sv
// Read-side port of the UART receiver: FIFO head, error flags, overrun pulse and occupancy.
// The receiver core is the master; the consuming register block is the slave.
interface uart_rx_core_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          rd_valid;
  logic                          rd_ready;
  logic [DATA_BITS-1:0]          rd_data;
  logic                          rd_frame_err;
  logic                          rd_parity_err;
  logic                          rd_break;
  logic                          overrun;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output rd_valid, rd_data, rd_frame_err, rd_parity_err, rd_break, overrun, fifo_count,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_data, rd_frame_err, rd_parity_err, rd_break, overrun, fifo_count,
    output rd_ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: synchronised rx line, mid-bit sampling FSM with
// parity/framing/break detection, and a first-word fall-through receive FIFO.
module uart_rx_core #(
  parameter int CLK_DIV    = 10,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            uart_clk,
  input  logic            uart_rst_n,
  input  logic            rx_data,
  uart_rx_core_if.master  rd
);
  localparam int CW  = $clog2(CLK_DIV);
  localparam int BCW = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 3;
  localparam logic [CW-1:0]  HALF_CNT  = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0]  LAST_CNT  = CW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  state_t state, state_next;

  logic rx_meta, rx_sync, rx_prev, fall;
  logic [CW-1:0] baud_cnt;
  logic sample, push;
  logic [DATA_BITS-1:0] shreg;
  logic [BCW-1:0] bit_cnt;
  logic stop_cnt, stop_err, stop_high, par_bit;
  logic frame_err_now, parity_err_now, break_now;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [EW-1:0] head;
  logic full, pop, wr_en;

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  // Reloaded on entering START and free-running afterwards, so every later
  // sample lands exactly one bit period after the previous mid-bit sample.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n)
      baud_cnt <= '0;
    else if (state == S_IDLE || state == S_BREAK_WAIT)
      baud_cnt <= '0;
    else if (baud_cnt == LAST_CNT)
      baud_cnt <= '0;
    else
      baud_cnt <= baud_cnt + 1'b1;
  end

  assign sample = (state != S_IDLE) && (state != S_BREAK_WAIT) && (baud_cnt == HALF_CNT);

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    unique case (state)
      S_IDLE:       if (fall) state_next = S_START;
      S_START:      if (sample) state_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:       if (sample && bit_cnt == LAST_BIT)
                      state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:     if (sample) state_next = S_STOP;
      S_STOP: begin
        if (sample && stop_cnt == LAST_STOP) begin
          push       = 1'b1;
          state_next = rx_sync ? S_IDLE : S_BREAK_WAIT;
        end
      end
      S_BREAK_WAIT: if (rx_sync) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      stop_err  <= 1'b0;
      stop_high <= 1'b0;
      par_bit   <= 1'b0;
    end else if (state == S_START) begin
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      stop_err  <= 1'b0;
      stop_high <= 1'b0;
      par_bit   <= 1'b0;
    end else if (sample) begin
      if (state == S_DATA) begin
        shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == S_PARITY)
        par_bit <= rx_sync;
      if (state == S_STOP) begin
        stop_cnt  <= stop_cnt + 1'b1;
        stop_err  <= stop_err | ~rx_sync;
        stop_high <= stop_high | rx_sync;
      end
    end
  end

  // Flags fold in the stop sample being taken on the push cycle itself.
  assign frame_err_now  = stop_err | ~rx_sync;
  assign parity_err_now = (PARITY == 1) ? ~(^shreg ^ par_bit) :
                          (PARITY == 2) ?  (^shreg ^ par_bit) : 1'b0;
  assign break_now      = (shreg == '0) && !par_bit && !stop_high && !rx_sync;

  assign full  = (count == FULL_CNT);
  assign pop   = rd.rd_valid && rd.rd_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge uart_clk) begin
    if (wr_en)
      mem[wr_ptr] <= {shreg, frame_err_now, parity_err_now, break_now};
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd.overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        count <= count + 1'b1;
      else if (!wr_en && pop)
        count <= count - 1'b1;
      rd.overrun <= push && full && !pop;
    end
  end

  assign head             = mem[rd_ptr];
  assign rd.rd_valid      = (count != '0);
  assign rd.rd_data       = rd.rd_valid ? head[EW-1:3] : '0;
  assign rd.rd_frame_err  = rd.rd_valid & head[2];
  assign rd.rd_parity_err = rd.rd_valid & head[1];
  assign rd.rd_break      = rd.rd_valid & head[0];
  assign rd.fifo_count    = count;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and an 8E2 instance, each fed by a
// bit-level line driver and checked against a frame-level scoreboard.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int CLK_DIV = 10;
  localparam int DEPTH   = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       brk;
  } frame_t;

  logic uart_clk   = 1'b0;
  logic uart_rst_n = 1'b0;
  logic rx_a       = 1'b1;
  logic rx_b       = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 0;
  int ovr_a = 0, ovr_b = 0, exp_ovr_a = 0, exp_ovr_b = 0;
  int pops_a = 0, pops_b = 0;
  logic ovr_a_prev = 1'b0, ovr_b_prev = 1'b0;
  frame_t q_a[$];
  frame_t q_b[$];
  frame_t last_a, last_b, act_a, act_b, exp_a, exp_b;

  always #5 uart_clk = ~uart_clk;

  uart_rx_core_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_a ();
  uart_rx_core_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_b ();

  uart_rx_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .uart_clk(uart_clk), .uart_rst_n(uart_rst_n), .rx_data(rx_a), .rd(if_a.master));
  uart_rx_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .uart_clk(uart_clk), .uart_rst_n(uart_rst_n), .rx_data(rx_b), .rd(if_b.master));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge uart_clk);
      #1;
    end
  endtask

  task automatic setLine(input int port, input logic v);
    if (port == 0) rx_a = v;
    else           rx_b = v;
  endtask

  // Serialises one frame and records the frame the receiver must deliver.
  task automatic applyStimulus(input int port, input logic [7:0] d, input int pforce,
                               input logic [1:0] stops, input int low_after, input int idle);
    int par_mode;
    int nstop;
    logic p;
    logic all_low;
    frame_t f;
    par_mode = (port == 0) ? 0 : 2;
    nstop    = (port == 0) ? 1 : 2;
    p = (par_mode == 1) ? ~^d : ^d;
    if (pforce >= 0) p = pforce[0];
    all_low = 1'b1;
    f.fe = 1'b0;
    for (int i = 0; i < nstop; i++) begin
      if (!stops[i]) f.fe = 1'b1;
      else           all_low = 1'b0;
    end
    f.data = d;
    f.pe   = (par_mode == 0) ? 1'b0 :
             (par_mode == 1) ? ((^d ^ p) != 1'b1) : ((^d ^ p) != 1'b0);
    f.brk  = (d == 8'h00) && (par_mode == 0 || p == 1'b0) && all_low;
    setLine(port, 1'b0);
    waitCycles(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      setLine(port, d[i]);
      waitCycles(CLK_DIV);
    end
    if (par_mode != 0) begin
      setLine(port, p);
      waitCycles(CLK_DIV);
    end
    for (int i = 0; i < nstop; i++) begin
      if (i == nstop - 1) begin
        if (port == 0) begin
          if (q_a.size() >= DEPTH) exp_ovr_a++;
          else q_a.push_back(f);
        end else begin
          if (q_b.size() >= DEPTH) exp_ovr_b++;
          else q_b.push_back(f);
        end
      end
      setLine(port, stops[i]);
      waitCycles(CLK_DIV);
    end
    if (low_after > 0) begin
      setLine(port, 1'b0);
      waitCycles(low_after);
    end
    setLine(port, 1'b1);
    waitCycles(idle);
  endtask

  task automatic drainWait();
    int k;
    k = 0;
    while (k < 600 && (q_a.size() != 0 || q_b.size() != 0 || if_a.rd_valid || if_b.rd_valid)) begin
      waitCycles(1);
      k++;
    end
    checkOutput("drain_a", q_a.size() + int'(if_a.rd_valid), 0);
    checkOutput("drain_b", q_b.size() + int'(if_b.rd_valid), 0);
  endtask

  initial begin
    if_a.rd_ready = 1'b0;
    if_b.rd_ready = 1'b0;
    forever begin
      @(posedge uart_clk);
      #1;
      case (ready_mode)
        0: begin if_a.rd_ready = 1'b0; if_b.rd_ready = 1'b0; end
        1: begin if_a.rd_ready = 1'b1; if_b.rd_ready = 1'b1; end
        default: begin
          if_a.rd_ready = ($urandom_range(3) != 0);
          if_b.rd_ready = ($urandom_range(3) != 0);
        end
      endcase
    end
  end

  // Scoreboard: every pop must match the head of the expected queue, and the
  // read port must be all-zero whenever nothing is valid.
  always @(negedge uart_clk) begin
    act_a = {if_a.rd_data, if_a.rd_frame_err, if_a.rd_parity_err, if_a.rd_break};
    act_b = {if_b.rd_data, if_b.rd_frame_err, if_b.rd_parity_err, if_b.rd_break};
    if (if_a.rd_valid && if_a.rd_ready) begin
      if (q_a.size() == 0) checkOutput("A_unexpected_frame", 32'(act_a), 32'hFFFF_FFFF);
      else begin
        exp_a = q_a.pop_front();
        checkOutput("A_frame", 32'(act_a), 32'(exp_a));
        last_a = act_a;
        pops_a++;
      end
    end else if (!if_a.rd_valid) checkOutput("A_idle_zero", 32'(act_a), 0);
    if (if_b.rd_valid && if_b.rd_ready) begin
      if (q_b.size() == 0) checkOutput("B_unexpected_frame", 32'(act_b), 32'hFFFF_FFFF);
      else begin
        exp_b = q_b.pop_front();
        checkOutput("B_frame", 32'(act_b), 32'(exp_b));
        last_b = act_b;
        pops_b++;
      end
    end else if (!if_b.rd_valid) checkOutput("B_idle_zero", 32'(act_b), 0);
    if (if_a.overrun) begin
      ovr_a++;
      checkOutput("A_overrun_width", {30'd0, ovr_a_prev, if_a.overrun}, 32'd1);
    end
    if (if_b.overrun) begin
      ovr_b++;
      checkOutput("B_overrun_width", {30'd0, ovr_b_prev, if_b.overrun}, 32'd1);
    end
    ovr_a_prev = if_a.overrun;
    ovr_b_prev = if_b.overrun;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int p0;
    int ob;
    logic [7:0] d99;
    logic [7:0] d;
    logic low;

    waitCycles(3);
    checkOutput("rst_a_outputs", {if_a.rd_valid, if_a.rd_data, if_a.rd_frame_err, if_a.rd_parity_err,
                                  if_a.rd_break, if_a.overrun, if_a.fifo_count}, 0);
    checkOutput("rst_b_outputs", {if_b.rd_valid, if_b.rd_data, if_b.rd_frame_err, if_b.rd_parity_err,
                                  if_b.rd_break, if_b.overrun, if_b.fifo_count}, 0);
    uart_rst_n = 1'b1;
    waitCycles(5);

    $display("[TB] back-to-back frames");
    ready_mode = 1;
    p0 = pops_a;
    applyStimulus(0, 8'h55, -1, 2'b11, 0, 0);
    applyStimulus(0, 8'hA3, -1, 2'b11, 0, 20);
    drainWait();
    checkOutput("t1_pops", pops_a - p0, 2);
    checkOutput("t1_last", 32'(last_a), 32'(frame_t'{8'hA3, 1'b0, 1'b0, 1'b0}));

    $display("[TB] start glitch");
    setLine(0, 1'b0);
    waitCycles(3);
    setLine(0, 1'b1);
    waitCycles(40);
    checkOutput("t2_count", 32'(if_a.fifo_count), 0);
    checkOutput("t2_valid", 32'(if_a.rd_valid), 0);

    $display("[TB] framing error and recovery");
    applyStimulus(0, 8'h3C, -1, 2'b00, 40, 20);
    drainWait();
    checkOutput("t3_frame", 32'(last_a), 32'(frame_t'{8'h3C, 1'b1, 1'b0, 1'b0}));
    applyStimulus(0, 8'h81, -1, 2'b11, 0, 20);
    applyStimulus(0, 8'h00, -1, 2'b00, 30, 20);
    drainWait();
    checkOutput("t3_break", 32'(last_a), 32'(frame_t'{8'h00, 1'b1, 1'b0, 1'b1}));

    $display("[TB] even parity, two stop bits");
    applyStimulus(1, 8'h07, 0, 2'b11, 0, 20);
    drainWait();
    checkOutput("t4_pe_bad", 32'(last_b.pe), 1);
    applyStimulus(1, 8'h07, 1, 2'b11, 0, 20);
    drainWait();
    checkOutput("t4_pe_good", 32'(last_b.pe), 0);
    applyStimulus(1, 8'h5A, -1, 2'b10, 0, 20);
    applyStimulus(1, 8'h00, -1, 2'b00, 30, 20);
    drainWait();
    checkOutput("t4_break", 32'(last_b), 32'(frame_t'{8'h00, 1'b1, 1'b0, 1'b1}));

    $display("[TB] overrun");
    ready_mode = 0;
    ob = ovr_a;
    for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), -1, 2'b11, 0, 2);
    waitCycles(20);
    checkOutput("t5_count", 32'(if_a.fifo_count), 4);
    checkOutput("t5_ovr_pulses", ovr_a - ob, 1);
    ready_mode = 1;
    drainWait();
    checkOutput("t5_last", 32'(last_a.data), 32'h04);
    checkOutput("t5_count_after", 32'(if_a.fifo_count), 0);

    $display("[TB] randomized frames");
    ready_mode = 2;
    for (int i = 0; i < 25; i++) begin
      d   = 8'($urandom_range(255));
      low = ($urandom_range(7) == 0);
      if (i % 9 == 4) d = 8'h00;
      if (low) applyStimulus(0, d, -1, 2'b00, $urandom_range(30, 5), $urandom_range(20, 5));
      else     applyStimulus(0, d, -1, 2'b11, 0, $urandom_range(15));
    end
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(255));
      applyStimulus(1, d, ($urandom_range(3) == 0) ? int'($urandom_range(1)) : -1,
                    ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : 2'b11, 0, 25);
    end
    drainWait();

    $display("[TB] reset mid-frame");
    ready_mode = 0;
    applyStimulus(0, 8'h11, -1, 2'b11, 0, 20);
    checkOutput("t6_pre_count", 32'(if_a.fifo_count), 1);
    d99 = 8'h99;
    setLine(0, 1'b0);
    waitCycles(CLK_DIV);
    for (int i = 0; i < 3; i++) begin
      setLine(0, d99[i]);
      waitCycles(CLK_DIV);
    end
    waitCycles(4);
    uart_rst_n = 1'b0;
    waitCycles(2);
    checkOutput("t6_rst_outputs", {if_a.rd_valid, if_a.rd_data, if_a.overrun, if_a.fifo_count}, 0);
    q_a.delete();
    setLine(0, 1'b1);
    waitCycles(5);
    uart_rst_n = 1'b1;
    waitCycles(40);
    checkOutput("t6_post_count", 32'(if_a.fifo_count), 0);
    ready_mode = 1;
    p0 = pops_a;
    applyStimulus(0, 8'h42, -1, 2'b11, 0, 20);
    drainWait();
    checkOutput("t6_pops", pops_a - p0, 1);
    checkOutput("t6_data", 32'(last_a.data), 32'h42);

    checkOutput("ovr_a_total", ovr_a, exp_ovr_a);
    checkOutput("ovr_b_total", ovr_b, exp_ovr_b);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
